// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch unit: FSM states, word size and the
// prefetch buffer entry layout.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    localparam int unsigned WORD_BYTES = 4;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Prefetch FIFO of fetched {instr, pc} entries; supports push and pop in the
// same cycle even when full, and a single-cycle flush.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int BUF_DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push,
    input  fetch_entry_t                  push_data,
    input  logic                          pop,
    input  logic                          flush,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(BUF_DEPTH):0]    count,
    output fetch_entry_t                  head
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] cnt_q;
    fetch_entry_t     mem [BUF_DEPTH];

    logic do_push;
    logic do_pop;

    assign full    = (cnt_q == CNT_W'(BUF_DEPTH));
    assign empty   = (cnt_q == '0);
    assign count   = cnt_q;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

    // Storage is data only; validity is tracked entirely by the pointers.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    assign head = empty ? '0 : mem[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: request FSM, fetch PC and prefetch buffer.
// Optional performance counters are built when FETCH_PERF_EN is defined.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        CLK,
    input  logic        RST,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_flush_cnt
`endif
);

    localparam int          CNT_W       = $clog2(BUF_DEPTH) + 1;
    localparam logic [31:0] RESET_PC_AL = {RESET_PC[31:2], 2'b00};

    fetch_state_t state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [31:0]  drain_addr_q;
    logic [31:0]  target_pc;

    logic             buf_push;
    logic             buf_pop;
    logic             buf_full;
    logic             buf_empty;
    logic [CNT_W-1:0] buf_count;
    fetch_entry_t     buf_in;
    fetch_entry_t     buf_head;

    assign target_pc   = align_word(redirect_pc);
    assign instr_valid = !buf_empty;
    // A redirect flushes the buffer, so a coincident handshake is moot.
    assign buf_pop     = instr_valid && instr_ready && !redirect_valid;
    assign buf_push    = (state_q == REQ) && imem_ack && !redirect_valid;
    assign buf_in      = '{instr: imem_rdata, pc: fetch_pc_q};

    // The abandoned request's address stays on the bus while draining.
    assign imem_addr = (state_q == DRAIN) ? drain_addr_q : fetch_pc_q;
    assign instr     = buf_head.instr;
    assign instr_pc  = buf_head.pc;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC_AL;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    always_ff @(posedge CLK) begin
        if ((state_q == REQ) && redirect_valid && !imem_ack) begin
            drain_addr_q <= fetch_pc_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        imem_req   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (redirect_valid) begin
                    fetch_pc_d = target_pc;
                end else if (buf_count < CNT_W'(BUF_DEPTH)) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                imem_req = 1'b1;
                if (redirect_valid) begin
                    fetch_pc_d = target_pc;
                    if (!imem_ack) begin
                        state_d = DRAIN;
                    end
                end else if (imem_ack) begin
                    fetch_pc_d = fetch_pc_q + 32'(WORD_BYTES);
                    // Keep streaming only if a slot remains after this push.
                    if (!((buf_count < CNT_W'(BUF_DEPTH - 1)) || buf_pop)) begin
                        state_d = IDLE;
                    end
                end
            end
            DRAIN: begin
                imem_req = 1'b1;
                if (redirect_valid) begin
                    fetch_pc_d = target_pc;
                end
                if (imem_ack) begin
                    state_d = REQ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    fetch_buffer #(
        .BUF_DEPTH (BUF_DEPTH)
    ) u_buffer (
        .clk       (CLK),
        .rst_n     (RST),
        .push      (buf_push),
        .push_data (buf_in),
        .pop       (buf_pop),
        .flush     (redirect_valid),
        .full      (buf_full),
        .empty     (buf_empty),
        .count     (buf_count),
        .head      (buf_head)
    );

`ifdef FETCH_PERF_EN
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            perf_fetch_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (buf_push) begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end
            if (redirect_valid) begin
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
            end
        end
    end
`endif

    logic unused_full;
    assign unused_full = buf_full;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed scenarios queue expected deliveries,
// a negedge monitor compares every instr handshake against the queue.
module tb_fetch_unit;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 CLK = ~CLK;

    // Memory model: the word at address A is ~A.
    assign imem_rdata = imem_req ? ~imem_addr : 32'hDEAD_BEEF;

    fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .BUF_DEPTH (2)
    ) dut (
        .CLK            (CLK),
        .RST            (RST),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_pc(input logic [31:0] pc);
        exp_t e;
        e.pc  = pc;
        e.ins = ~pc;
        sb.push_back(e);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Leaves the bench one time unit after a rising edge with RST still low.
    task automatic do_reset();
        RST = 1'b0;
        #1;
        chk("rst_async_req", {31'd0, imem_req}, 32'd0);
        chk("rst_async_valid", {31'd0, instr_valid}, 32'd0);
        imem_ack       = 1'b0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        cyc(2);
        chk("rst_addr", imem_addr, 32'h0000_0000);
        chk("rst_instr", instr, 32'h0);
        chk("rst_instr_pc", instr_pc, 32'h0);
        chk("sb_drained", sb.size(), 32'd0);
        sb.delete();
    endtask

    always @(negedge CLK) begin
        if (RST && instr_valid && instr_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL deliver_unexpected: got pc %h, none expected", instr_pc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("deliver_pc", instr_pc, e.pc);
                chk("deliver_instr", instr, e.ins);
            end
        end
    end

    initial begin
        // Zero-wait memory, always-ready consumer: one instruction per cycle.
        do_reset();
        expect_pc(32'h0); expect_pc(32'h4); expect_pc(32'h8); expect_pc(32'hC);
        imem_ack = 1'b1; instr_ready = 1'b1; RST = 1'b1;
        cyc(1);
        chk("a_req", {31'd0, imem_req}, 32'd1);
        chk("a_addr0", imem_addr, 32'h0);
        chk("a_no_valid_yet", {31'd0, instr_valid}, 32'd0);
        cyc(1);
        chk("a_valid", {31'd0, instr_valid}, 32'd1);
        chk("a_pc0", instr_pc, 32'h0);
        cyc(1); chk("a_pc4", instr_pc, 32'h4);
        cyc(1); chk("a_pc8", instr_pc, 32'h8);
        cyc(1); chk("a_pc12", instr_pc, 32'hC);
        cyc(1); instr_ready = 1'b0;

        // Stalled consumer: buffer fills to two entries and requests stop.
        do_reset();
        expect_pc(32'h0); expect_pc(32'h4); expect_pc(32'h8);
        imem_ack = 1'b1; instr_ready = 1'b0; RST = 1'b1;
        cyc(3);
        chk("b_req_drop", {31'd0, imem_req}, 32'd0);
        cyc(2);
        chk("b_req_still_low", {31'd0, imem_req}, 32'd0);
        chk("b_valid_held", {31'd0, instr_valid}, 32'd1);
        chk("b_pc_held", instr_pc, 32'h0);
        instr_ready = 1'b1;
        cyc(4);
        instr_ready = 1'b0;

        // Redirect with a slow memory: old request drained, then fetch 0x100.
        do_reset();
        imem_ack = 1'b0; instr_ready = 1'b1; RST = 1'b1;
        cyc(1);
        chk("c_addr_before", imem_addr, 32'h0);
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
        cyc(1);
        redirect_valid = 1'b0;
        chk("c_drain_req", {31'd0, imem_req}, 32'd1);
        chk("c_drain_addr1", imem_addr, 32'h0);
        cyc(1);
        chk("c_drain_addr2", imem_addr, 32'h0);
        chk("c_no_valid", {31'd0, instr_valid}, 32'd0);
        cyc(1);
        imem_ack = 1'b1;
        chk("c_addr_at_ack", imem_addr, 32'h0);
        cyc(1);
        chk("c_new_addr", imem_addr, 32'h0000_0100);
        chk("c_new_req", {31'd0, imem_req}, 32'd1);
        chk("c_discarded", {31'd0, instr_valid}, 32'd0);
        expect_pc(32'h0000_0100);
        cyc(1);
        imem_ack = 1'b0;
        chk("c_first_pc", instr_pc, 32'h0000_0100);
`ifdef FETCH_PERF_EN
        chk("c_perf_flush", perf_flush_cnt, 32'd1);
        chk("c_perf_fetch", perf_fetch_cnt, 32'd1);
`endif
        cyc(1);

        // Redirect coincident with the ack for address 8 (reset also abandons
        // the request left outstanding above).
        do_reset();
        expect_pc(32'h0); expect_pc(32'h0000_0200);
        imem_ack = 1'b1; instr_ready = 1'b1; RST = 1'b1;
        cyc(3);
        chk("d_addr8", imem_addr, 32'h8);
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0200; instr_ready = 1'b0;
        cyc(1);
        redirect_valid = 1'b0; instr_ready = 1'b1;
        chk("d_flushed", {31'd0, instr_valid}, 32'd0);
        chk("d_target_addr", imem_addr, 32'h0000_0200);
        cyc(1);
        chk("d_target_pc", instr_pc, 32'h0000_0200);
        cyc(1);
        instr_ready = 1'b0;

        // Address wrap from the top word to zero.
        do_reset();
        expect_pc(32'hFFFF_FFFC); expect_pc(32'h0);
        imem_ack = 1'b0; instr_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; RST = 1'b1;
        cyc(1);
        redirect_valid = 1'b0; imem_ack = 1'b1;
        chk("e_idle_on_redirect", {31'd0, imem_req}, 32'd0);
        cyc(1);
        chk("e_addr_top", imem_addr, 32'hFFFF_FFFC);
        cyc(1);
        chk("e_pc_top", instr_pc, 32'hFFFF_FFFC);
        chk("e_addr_wrap", imem_addr, 32'h0);
        cyc(1);
        chk("e_pc_wrap", instr_pc, 32'h0);
        cyc(1);
        instr_ready = 1'b0;

        do_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
